// File: rtl/main_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// main_mem_arbiter_pkg
// Shared definitions for the main-memory arbiter slice: default bus widths,
// access-type encodings, the debug queue entry layout and the queue
// occupancy states.
// -----------------------------------------------------------------------------
package main_mem_arbiter_pkg;

  localparam int AW_DEF = 12;
  localparam int DW_DEF = 16;

  // Access type carried in the rw field of a request.
  localparam logic ACC_READ  = 1'b0;
  localparam logic ACC_WRITE = 1'b1;

  // Debug queue entry at the default widths; the top re-declares the same
  // layout at its own parameterised widths.
  typedef struct packed {
    logic              rw;
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] wdata;
  } dbg_entry_t;

  // Queue occupancy; the encoding equals the entry count.
  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } q_state_e;

endpackage

// File: rtl/main_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// main_mem_arbiter_if
// Debug/loader port of the main-memory arbiter.
//   master : host side (drives requests, starvation clear)
//   slave  : arbiter side (drives ready, read response, starvation flag)
// Signals:
//   dbg_req, dbg_rw, dbg_addr, dbg_wdata : request (accepted on req & ready)
//   dbg_ready                            : queue can accept
//   dbg_rvalid, dbg_rdata                : one-cycle read response
//   dbg_starved, dbg_starved_clr         : sticky starvation flag and clear
// -----------------------------------------------------------------------------
interface main_mem_arbiter_if
  import main_mem_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          dbg_req;
  logic          dbg_ready;
  logic          dbg_rw;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_starved;
  logic          dbg_starved_clr;

  modport master (
    output dbg_req, dbg_rw, dbg_addr, dbg_wdata, dbg_starved_clr,
    input  dbg_ready, dbg_rvalid, dbg_rdata, dbg_starved
  );

  modport slave (
    input  dbg_req, dbg_rw, dbg_addr, dbg_wdata, dbg_starved_clr,
    output dbg_ready, dbg_rvalid, dbg_rdata, dbg_starved
  );

endinterface

// File: rtl/main_mem_arbiter_dbg_req_fifo.sv
// -----------------------------------------------------------------------------
// main_mem_arbiter_dbg_req_fifo
// Two-entry in-order request queue. Slot 0 always holds the head.
// Ports:
//   clock, reset : clock, async active-high reset
//   push_i       : write din_i this edge (ignored when full)
//   pop_i        : drop the head this edge (ignored when empty)
//   din_i        : entry to enqueue
//   head_o       : current head entry
//   full_o       : two entries held
//   empty_o      : no entries held
// -----------------------------------------------------------------------------
module main_mem_arbiter_dbg_req_fifo
  import main_mem_arbiter_pkg::*;
#(
  parameter type entry_t = dbg_entry_t
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   push_i,
  input  logic   pop_i,
  input  entry_t din_i,
  output entry_t head_o,
  output logic   full_o,
  output logic   empty_o
);

  q_state_e state_q, state_d;
  entry_t   slot0_q, slot0_d;
  entry_t   slot1_q, slot1_d;

  // Occupancy state and storage registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= Q_EMPTY;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      state_q <= state_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  // Next occupancy and slot contents from push/pop.
  always_comb begin
    state_d = state_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    case (state_q)
      Q_EMPTY: begin
        if (push_i) begin
          slot0_d = din_i;
          state_d = Q_ONE;
        end else begin
          state_d = Q_EMPTY;
        end
      end
      Q_ONE: begin
        if (push_i && pop_i) begin
          // Head leaves and the new entry becomes the head.
          slot0_d = din_i;
          state_d = Q_ONE;
        end else if (push_i) begin
          slot1_d = din_i;
          state_d = Q_FULL;
        end else if (pop_i) begin
          state_d = Q_EMPTY;
        end else begin
          state_d = Q_ONE;
        end
      end
      Q_FULL: begin
        // No push can arrive here: ready is low while full.
        if (pop_i) begin
          slot0_d = slot1_q;
          state_d = Q_ONE;
        end else begin
          state_d = Q_FULL;
        end
      end
      default: begin
        state_d = Q_EMPTY;
      end
    endcase
  end

  assign head_o  = slot0_q;
  assign full_o  = (state_q == Q_FULL);
  assign empty_o = (state_q == Q_EMPTY);

endmodule

// File: rtl/main_mem_arbiter.sv
// -----------------------------------------------------------------------------
// main_mem_arbiter
// Shares the single-port main data memory between the processor MEM-stage
// port (absolute priority, never stalled) and a debug/loader port whose
// requests are queued and issued in memory cycles the CPU leaves idle.
// Ports:
//   clock, reset          : clock, async active-high reset
//   cpu_req_i/rw_i/addr_i/data_i : CPU access this cycle
//   cpu_q_o               : read data to CPU (straight from the RAM)
//   dbg                   : debug port (main_mem_arbiter_if.slave)
//   mem_addr_o/data_o/rw_o: RAM address, write data, write enable
//   mem_q_i               : RAM read data, MEM_LAT cycles after the address
// -----------------------------------------------------------------------------
module main_mem_arbiter
  import main_mem_arbiter_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cpu_req_i,
  input  logic                cpu_rw_i,
  input  logic [AW-1:0]       cpu_addr_i,
  input  logic [DW-1:0]       cpu_data_i,
  output logic [DW-1:0]       cpu_q_o,
  main_mem_arbiter_if.slave   dbg,
  output logic [AW-1:0]       mem_addr_o,
  output logic [DW-1:0]       mem_data_o,
  output logic                mem_rw_o,
  input  logic [DW-1:0]       mem_q_i
);

  // Counter wide enough for the limit, never narrower than 8 bits.
  localparam int CW = ($clog2(STARVE_LIMIT + 1) > 8) ? $clog2(STARVE_LIMIT + 1) : 8;

  typedef struct packed {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } entry_t;

  entry_t               fifo_din_s;
  entry_t               fifo_head_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic                 push_s;
  logic                 issue_s;
  logic                 mem_rw_s;
  logic [MEM_LAT-1:0]   trk_q, trk_d;
  logic [CW-1:0]        starve_cnt_q, starve_cnt_d;
  logic                 starved_q, starved_d;
  logic                 starve_inc_s;
  logic                 starve_set_s;

  // Ready depends only on registered occupancy, so no path from dbg_req.
  assign dbg.dbg_ready = ~fifo_full_s;
  assign push_s        = dbg.dbg_req & ~fifo_full_s;
  // The queue head issues only in a cycle the CPU does not use.
  assign issue_s       = ~cpu_req_i & ~fifo_empty_s;
  assign fifo_din_s    = {dbg.dbg_rw, dbg.dbg_addr, dbg.dbg_wdata};

  main_mem_arbiter_dbg_req_fifo #(
    .entry_t (entry_t)
  ) u_dbg_req_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push_s),
    .pop_i   (issue_s),
    .din_i   (fifo_din_s),
    .head_o  (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Zero-latency memory mux: CPU first, then the queue head, else idle.
  always_comb begin
    mem_addr_o = cpu_addr_i;
    mem_data_o = cpu_data_i;
    mem_rw_s   = 1'b0;
    if (cpu_req_i) begin
      mem_addr_o = cpu_addr_i;
      mem_data_o = cpu_data_i;
      mem_rw_s   = cpu_rw_i;
    end else if (issue_s) begin
      mem_addr_o = fifo_head_s.addr;
      mem_data_o = fifo_head_s.wdata;
      mem_rw_s   = fifo_head_s.rw;
    end else begin
      mem_addr_o = cpu_addr_i;
      mem_data_o = cpu_data_i;
      mem_rw_s   = 1'b0;
    end
    // No RAM write can slip out while reset is held.
    mem_rw_o = mem_rw_s & ~reset;
  end

  // Read-tracking shift: a bit enters at a debug read issue and emerges
  // after MEM_LAT edges, aligned with that read's data on mem_q.
  always_comb begin
    trk_d    = trk_q;
    trk_d[0] = issue_s & (fifo_head_s.rw == ACC_READ);
    for (int i = 1; i < MEM_LAT; i++) begin
      trk_d[i] = trk_q[i-1];
    end
  end

  // Starvation: count cycles a queued head is blocked by the CPU.
  always_comb begin
    starve_inc_s = cpu_req_i & ~fifo_empty_s;
    if (starve_inc_s) begin
      if (starve_cnt_q == {CW{1'b1}}) begin
        starve_cnt_d = starve_cnt_q;
      end else begin
        starve_cnt_d = starve_cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      // Empty queue or an issue this cycle restarts the wait.
      starve_cnt_d = {CW{1'b0}};
    end
    starve_set_s = starve_inc_s & (starve_cnt_d >= CW'(STARVE_LIMIT));
    // A set in the same cycle as a clear wins.
    if (starve_set_s) begin
      starved_d = 1'b1;
    end else if (dbg.dbg_starved_clr) begin
      starved_d = 1'b0;
    end else begin
      starved_d = starved_q;
    end
  end

  // Tracking and starvation registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      trk_q        <= {MEM_LAT{1'b0}};
      starve_cnt_q <= {CW{1'b0}};
      starved_q    <= 1'b0;
    end else begin
      trk_q        <= trk_d;
      starve_cnt_q <= starve_cnt_d;
      starved_q    <= starved_d;
    end
  end

  assign dbg.dbg_rvalid  = trk_q[MEM_LAT-1];
  assign dbg.dbg_rdata   = trk_q[MEM_LAT-1] ? mem_q_i : {DW{1'b0}};
  assign dbg.dbg_starved = starved_q;
  assign cpu_q_o         = mem_q_i;

endmodule

// File: tb/tb_main_mem_arbiter.sv
module tb_main_mem_arbiter;

  localparam int AW  = 12;
  localparam int DW  = 16;
  localparam int LAT = 3;
  localparam int LIM = 4;

  logic          clock;
  logic          reset;
  logic          cpu_req;
  logic          cpu_rw;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_data;
  logic [DW-1:0] cpu_q;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_rw;
  logic [DW-1:0] mem_q;

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;

  main_mem_arbiter_if #(.AW(AW), .DW(DW)) dbg_if ();

  main_mem_arbiter #(
    .AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_LIMIT(LIM)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_req_i  (cpu_req),
    .cpu_rw_i   (cpu_rw),
    .cpu_addr_i (cpu_addr),
    .cpu_data_i (cpu_data),
    .cpu_q_o    (cpu_q),
    .dbg        (dbg_if.slave),
    .mem_addr_o (mem_addr),
    .mem_data_o (mem_data),
    .mem_rw_o   (mem_rw),
    .mem_q_i    (mem_q)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {4'h0, a} ^ 16'h5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Synchronous RAM with LAT cycles from address to data.
  logic [DW-1:0] ram  [0:(1<<AW)-1];
  logic [DW-1:0] pipe [LAT];
  assign mem_q = pipe[LAT-1];

  initial begin
    for (int a = 0; a < (1 << AW); a++) ram[a] <= pat(AW'(a));
    for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    forever begin
      @(posedge clock);
      for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= ram[mem_addr];
      if (mem_rw) ram[mem_addr] <= mem_data;
    end
  end

  // Behavioural model: request queue, shadow memory in issue order,
  // response list with due cycles, wait counter for starvation.
  typedef struct { logic rw; logic [AW-1:0] addr; logic [DW-1:0] data; } req_t;
  typedef struct { int due; logic [DW-1:0] data; } rsp_t;
  req_t          mq[$];
  rsp_t          rq[$];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  int            waited;
  logic          starved_m;

  initial begin
    logic          issue, accept, er, rv_exp;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    req_t          nr;
    rsp_t          ns;
    for (int a = 0; a < (1 << AW); a++) shadow[a] = pat(AW'(a));
    waited = 0;
    starved_m = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        mq.delete();
        rq.delete();
        waited = 0;
        starved_m = 1'b0;
        chk("m_rst_mem_rw", 32'(mem_rw), 32'h0);
        chk("m_rst_ready", 32'(dbg_if.dbg_ready), 32'h1);
        chk("m_rst_rvalid", 32'(dbg_if.dbg_rvalid), 32'h0);
        chk("m_rst_starved", 32'(dbg_if.dbg_starved), 32'h0);
      end else begin
        issue = !cpu_req && (mq.size() != 0);
        if (cpu_req) begin
          ea = cpu_addr; ed = cpu_data; er = cpu_rw;
        end else if (issue) begin
          ea = mq[0].addr; ed = mq[0].data; er = mq[0].rw;
        end else begin
          ea = cpu_addr; ed = cpu_data; er = 1'b0;
        end
        chk("m_mem_addr", 32'(mem_addr), 32'(ea));
        chk("m_mem_data", 32'(mem_data), 32'(ed));
        chk("m_mem_rw", 32'(mem_rw), 32'(er));
        chk("m_ready", 32'(dbg_if.dbg_ready), 32'(mq.size() < 2));
        chk("m_cpu_q", 32'(cpu_q), 32'(mem_q));
        chk("m_starved", 32'(dbg_if.dbg_starved), 32'(starved_m));
        rv_exp = (rq.size() != 0) && (rq[0].due == cyc);
        chk("m_rvalid", 32'(dbg_if.dbg_rvalid), 32'(rv_exp));
        if (rv_exp) begin
          chk("m_rdata", 32'(dbg_if.dbg_rdata), 32'(rq[0].data));
          void'(rq.pop_front());
        end
        // Advance model to the state after this edge.
        if (issue && !mq[0].rw) begin
          ns.due = cyc + LAT;
          ns.data = shadow[mq[0].addr];
          rq.push_back(ns);
        end
        if (er) shadow[ea] = ed;
        if ((mq.size() != 0) && cpu_req) begin
          waited++;
          if (waited >= LIM) starved_m = 1'b1;
          else if (dbg_if.dbg_starved_clr) starved_m = 1'b0;
        end else begin
          waited = 0;
          if (dbg_if.dbg_starved_clr) starved_m = 1'b0;
        end
        accept = dbg_if.dbg_req && (mq.size() < 2);
        if (issue) void'(mq.pop_front());
        if (accept) begin
          nr.rw = dbg_if.dbg_rw; nr.addr = dbg_if.dbg_addr; nr.data = dbg_if.dbg_wdata;
          mq.push_back(nr);
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic idle();
    cpu_req = 1'b0; cpu_rw = 1'b0;
    dbg_if.dbg_req = 1'b0; dbg_if.dbg_starved_clr = 1'b0;
  endtask

  task automatic dreq(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    dbg_if.dbg_req = 1'b1; dbg_if.dbg_rw = rw; dbg_if.dbg_addr = a; dbg_if.dbg_wdata = d;
  endtask

  // Directed stimulus with hand-computed expectations (LAT=3, LIM=4).
  initial begin
    reset = 1'b1;
    idle();
    dbg_if.dbg_rw = 1'b0; dbg_if.dbg_addr = '0; dbg_if.dbg_wdata = '0;
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 12'h3FF; cpu_data = 16'hFFFF;
    repeat (2) nxt();
    mid();
    chk("rst_ready", 32'(dbg_if.dbg_ready), 32'h1);
    chk("rst_rvalid", 32'(dbg_if.dbg_rvalid), 32'h0);
    chk("rst_starved", 32'(dbg_if.dbg_starved), 32'h0);
    chk("rst_mem_rw", 32'(mem_rw), 32'h0);
    nxt();
    reset = 1'b0; idle();
    nxt();

    // Debug write then read of 0x010 with the CPU idle.
    dreq(1'b1, 12'h010, 16'hBEEF); nxt();
    dreq(1'b0, 12'h010, 16'h0000); mid();
    chk("t1_wr_rw", 32'(mem_rw), 32'h1);
    chk("t1_wr_addr", 32'(mem_addr), 32'h010);
    chk("t1_wr_data", 32'(mem_data), 32'hBEEF);
    nxt();
    dbg_if.dbg_req = 1'b0; mid();
    chk("t1_rd_rw", 32'(mem_rw), 32'h0);
    chk("t1_rd_addr", 32'(mem_addr), 32'h010);
    nxt();
    for (int k = 3; k <= 6; k++) begin
      mid();
      if (k == 5) begin
        chk("t1_rvalid", 32'(dbg_if.dbg_rvalid), 32'h1);
        chk("t1_rdata", 32'(dbg_if.dbg_rdata), 32'hBEEF);
      end else begin
        chk("t1_rvalid_low", 32'(dbg_if.dbg_rvalid), 32'h0);
      end
      nxt();
    end

    // Read 0x020 held off by 5 CPU cycles; starvation sets and is cleared.
    dreq(1'b0, 12'h020, 16'h0000); nxt();
    for (int i = 1; i <= 5; i++) begin
      dbg_if.dbg_req = 1'b0; cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 12'h100 + 12'(i);
      mid();
      chk("t2_cpu_addr", 32'(mem_addr), 32'h100 + 32'(i));
      chk("t2_cpu_rw", 32'(mem_rw), 32'h0);
      chk("t2_starved", 32'(dbg_if.dbg_starved), 32'(i == 5));
      nxt();
    end
    idle(); mid();
    chk("t2_issue_addr", 32'(mem_addr), 32'h020);
    chk("t2_issue_rw", 32'(mem_rw), 32'h0);
    nxt();
    for (int k = 7; k <= 9; k++) begin
      mid();
      if (k == 9) begin
        chk("t2_rvalid", 32'(dbg_if.dbg_rvalid), 32'h1);
        chk("t2_rdata", 32'(dbg_if.dbg_rdata), 32'h5A7A);
        chk("t2_starved_kept", 32'(dbg_if.dbg_starved), 32'h1);
      end else begin
        chk("t2_rvalid_low", 32'(dbg_if.dbg_rvalid), 32'h0);
      end
      nxt();
    end
    dbg_if.dbg_starved_clr = 1'b1; mid(); nxt();
    dbg_if.dbg_starved_clr = 1'b0; mid();
    chk("t4_starved_clr", 32'(dbg_if.dbg_starved), 32'h0);
    nxt();

    // Three back-to-back pushes while the CPU is busy.
    cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 12'h200;
    dreq(1'b1, 12'h040, 16'h1111); mid();
    chk("t3_ready0", 32'(dbg_if.dbg_ready), 32'h1);
    nxt();
    dreq(1'b1, 12'h041, 16'h2222); mid();
    chk("t3_ready1", 32'(dbg_if.dbg_ready), 32'h1);
    nxt();
    dreq(1'b0, 12'h040, 16'h0000); mid();
    chk("t3_full", 32'(dbg_if.dbg_ready), 32'h0);
    nxt();
    cpu_req = 1'b0; mid();
    chk("t3_held", 32'(dbg_if.dbg_ready), 32'h0);
    chk("t3_iss1_addr", 32'(mem_addr), 32'h040);
    chk("t3_iss1_data", 32'(mem_data), 32'h1111);
    chk("t3_iss1_rw", 32'(mem_rw), 32'h1);
    nxt();
    mid();
    chk("t3_ready_again", 32'(dbg_if.dbg_ready), 32'h1);
    chk("t3_iss2_addr", 32'(mem_addr), 32'h041);
    chk("t3_iss2_data", 32'(mem_data), 32'h2222);
    nxt();
    dbg_if.dbg_req = 1'b0; mid();
    chk("t3_iss3_addr", 32'(mem_addr), 32'h040);
    chk("t3_iss3_rw", 32'(mem_rw), 32'h0);
    nxt();
    repeat (2) nxt();
    mid();
    chk("t3_rvalid", 32'(dbg_if.dbg_rvalid), 32'h1);
    chk("t3_rdata", 32'(dbg_if.dbg_rdata), 32'h1111);
    nxt();

    // CPU store then debug read of the same address.
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 12'h030; cpu_data = 16'h1234; mid();
    chk("t5_st_rw", 32'(mem_rw), 32'h1);
    chk("t5_st_addr", 32'(mem_addr), 32'h030);
    nxt();
    idle(); dreq(1'b0, 12'h030, 16'h0000); nxt();
    dbg_if.dbg_req = 1'b0; mid();
    chk("t5_issue_addr", 32'(mem_addr), 32'h030);
    nxt();
    repeat (2) nxt();
    mid();
    chk("t5_rvalid", 32'(dbg_if.dbg_rvalid), 32'h1);
    chk("t5_rdata", 32'(dbg_if.dbg_rdata), 32'h1234);
    nxt();

    // Reset with two queued requests, one read in flight, starved set.
    dreq(1'b1, 12'h060, 16'hAAAA); nxt();
    dbg_if.dbg_req = 1'b0; cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 12'h300;
    repeat (4) nxt();
    cpu_req = 1'b0; dreq(1'b0, 12'h050, 16'h0000); mid();
    chk("t6_starved_pre", 32'(dbg_if.dbg_starved), 32'h1);
    chk("t6_wr_addr", 32'(mem_addr), 32'h060);
    nxt();
    dreq(1'b0, 12'h051, 16'h0000); nxt();
    cpu_req = 1'b1; dreq(1'b0, 12'h052, 16'h0000); mid();
    chk("t6_ready_pre", 32'(dbg_if.dbg_ready), 32'h1);
    nxt();
    reset = 1'b1; dbg_if.dbg_req = 1'b0;
    cpu_rw = 1'b1; cpu_addr = 12'h301; cpu_data = 16'hDEAD; mid();
    chk("t6_rst_mem_rw", 32'(mem_rw), 32'h0);
    chk("t6_rst_ready", 32'(dbg_if.dbg_ready), 32'h1);
    chk("t6_rst_starved", 32'(dbg_if.dbg_starved), 32'h0);
    chk("t6_rst_rvalid", 32'(dbg_if.dbg_rvalid), 32'h0);
    nxt();
    mid();
    chk("t6_rst_rvalid2", 32'(dbg_if.dbg_rvalid), 32'h0);
    nxt();
    reset = 1'b0; idle();
    for (int k = 0; k < 8; k++) begin
      mid();
      chk("t6_no_rvalid", 32'(dbg_if.dbg_rvalid), 32'h0);
      chk("t6_no_issue_rw", 32'(mem_rw), 32'h0);
      chk("t6_ready_post", 32'(dbg_if.dbg_ready), 32'h1);
      nxt();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/main_mem_arbiter.md
Name: main_mem_arbiter

Overview:
Shares the single-port main data memory between the pipelined processor's MEM-stage port and a debug/loader port (host-side program/data inspection and patching).
- CPU has absolute priority; the processor pipeline cannot stall.
- Debug accesses are buffered in a 2-entry queue and issued in idle memory cycles, with ordered read responses and starvation reporting.
- Sits between the processor's main_m_* port and the main memory instance.

Parameters:
- AW, 12, memory address width
- DW, 16, data width
- MEM_LAT, 1, cycles from address presented to mem_q valid (synchronous RAM, 1..3)
- STARVE_LIMIT, 255, consecutive cycles a queued debug request may wait before dbg_starved sets

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- cpu_req  in  1  CPU performs LD/ST this cycle
- cpu_rw  in  1  1=write (ST)
- cpu_addr  in  AW  CPU address
- cpu_data  in  DW  CPU write data
- cpu_q  out  DW  read data to CPU (= mem_q)
- dbg_req  in  1  debug request valid
- dbg_ready  out  1  queue can accept (not full)
- dbg_rw  in  1  1=write
- dbg_addr  in  AW  debug address
- dbg_wdata  in  DW  debug write data
- dbg_rvalid  out  1  debug read data valid (1-cycle pulse per read)
- dbg_rdata  out  DW  debug read data
- dbg_starved  out  1  sticky starvation flag
- dbg_starved_clr  in  1  clears dbg_starved
- mem_addr  out  AW  to RAM
- mem_data  out  DW  to RAM
- mem_rw  out  1  RAM write enable
- mem_q  in  DW  from RAM

Behaviour:
- Acceptance: request accepted on a clock edge where dbg_req & dbg_ready. dbg_ready = queue count < 2; registered-state-derived, no combinational path from dbg_req.
- Queue: 2-entry FIFO of {rw, addr, wdata}, in order.
  - Simultaneous accept and issue with count 2 is impossible (ready=0).
  - At count 1, accept plus issue keeps count 1.
- Mux (combinational, zero latency):
  - cpu_req=1: mem_* = cpu_*.
  - Else if queue non-empty: mem_* = head entry, and the head pops at this edge (issue).
  - Else: mem_addr=cpu_addr, mem_data=cpu_data, mem_rw=0.
  - mem_rw is 0 while reset is asserted.
- CPU collision: cpu_req always wins; the head entry stays queued; no CPU-visible effect.
- Read tracking: shift register of MEM_LAT valid bits, tagged "debug read" at issue of a queued read.
  - dbg_rvalid=1 and dbg_rdata=mem_q exactly MEM_LAT cycles after the issue cycle.
  - Responses come in issue order; debug writes produce no response.
  - cpu_q = mem_q unconditionally; the CPU uses it only for its own reads.
- Read-after-write: a debug write followed by a read to the same address returns the new data (memory order = issue order).
- Starvation counter (8+ bits, saturating):
  - Increments each cycle the queue is non-empty and cpu_req=1.
  - Resets to 0 on any issue or when the queue is empty.
  - Reaching STARVE_LIMIT sets dbg_starved.
  - dbg_starved_clr clears it; a set in the same cycle wins.
- Reset (async): queue empty, dbg_ready=1 after release, read-tracking bits 0, dbg_rvalid=0, dbg_rdata=0, counter=0, dbg_starved=0.
  - Reset mid-operation discards queued and in-flight debug requests; no dbg_rvalid is produced for them.
- State machine: implicit in queue count, states EMPTY(0) / ONE(1) / FULL(2).
  - EMPTY→ONE on accept.
  - ONE→EMPTY on issue without accept.
  - ONE→FULL on accept without issue.
  - FULL→ONE on issue.

Decomposition:
- Shared package: AW/DW defaults, access-type constants (ACC_READ=0, ACC_WRITE=1), queue entry struct {rw, addr, wdata}.
- One sub-module is natural: dbg_req_fifo (2-entry FIFO with count, push/pop, full/empty).
- Mux, read-tracking shift register and starvation counter stay in main_mem_arbiter.

Test Plan:
- Idle CPU, debug write addr 0x010 data 0xBEEF, then read 0x010 → both issue on consecutive cycles; dbg_rvalid pulses MEM_LAT cycles after the read issue with dbg_rdata=0xBEEF.
- cpu_req=1 for 5 cycles with debug read to 0x020 queued → mem_addr follows cpu_addr for all 5 cycles; debug read issues in cycle 6; rvalid MEM_LAT later.
- Push 3 debug requests back-to-back while cpu_req=1 → first two accepted, dbg_ready=0, third held; third accepted after the first issue; all complete in order.
- STARVE_LIMIT=4, cpu_req held high with a queued request → dbg_starved=1 after 4 cycles; stays set after the issue; dbg_starved_clr → 0.
- CPU ST 0x1234 to 0x030, next cycle debug read 0x030 (cpu idle) → dbg_rdata=0x1234.
- Assert reset with 2 queued requests and 1 read in flight → no dbg_rvalid afterward; dbg_ready=1, dbg_starved=0, mem_rw=0 during reset.
